rob_ptr_ctrl: RTL
=================

# rob_ptr_ctrl

Reorder-buffer pointer controller. It owns the ROB head (commit) and tail (allocate) indices, the occupancy count and the full/empty status. It hands out one entry per cycle to dispatch, retires one entry per cycle to commit, and rolls the tail back on a branch-mispredict or exception flush. It sits between dispatch, commit and the ROB storage array, and drives the array's write and read indices.

## Interface
Parameters:
- ROB_SIZE, 40, number of ROB entries; need not be a power of two
- ROB_IDX_W, 6, index width; must satisfy 2^ROB_IDX_W >= ROB_SIZE

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alloc_valid  in  1  dispatch requests one entry
- alloc_ready  out  1  entry can be granted this cycle
- alloc_idx  out  ROB_IDX_W  index granted on alloc_valid&&alloc_ready (= tail)
- commit_valid  in  1  head entry is complete and retires
- commit_ready  out  1  a retire is accepted this cycle
- commit_idx  out  ROB_IDX_W  index retiring (= head)
- flush_valid  in  1  squash all entries from flush_idx up to tail
- flush_idx  in  ROB_IDX_W  new tail after the flush; oldest squashed entry
- head  out  ROB_IDX_W  current head index
- tail  out  ROB_IDX_W  current tail index
- occupancy  out  ROB_IDX_W+1  number of live entries, 0..ROB_SIZE
- full  out  1  occupancy == ROB_SIZE
- empty  out  1  occupancy == 0

## Operation
- State registers: head, tail, occupancy. full and empty are registered, next-state derived.
- Index increment: idx == ROB_SIZE-1 -> 0, else idx+1. Never reaches ROB_SIZE..2^W-1.
- Grants:
  - alloc_fire = alloc_valid && alloc_ready, where alloc_ready = !full && !flush_valid.
  - commit_fire = commit_valid && commit_ready, where commit_ready = !empty && !flush_valid.
- Normal cycle:
  - alloc_fire advances tail.
  - commit_fire advances head.
  - occupancy changes by +alloc_fire - commit_fire. Both firing leaves it unchanged.
- Flush has top priority. Alloc and commit are blocked in the flush cycle.
  - tail <= flush_idx; head holds.
  - occupancy <= dist(head, flush_idx) = flush_idx - head, plus ROB_SIZE if negative. Computed at ROB_IDX_W+1 bits.
  - flush_idx == head empties the ROB (exception / full squash).
- Legal flush_idx lies circularly in [head, tail]. Out-of-range values are illegal and are flagged by a bench assertion, not handled in RTL.
- full implies alloc_ready = 0. A commit alone may fire, freeing one slot next cycle.
- empty implies commit_ready = 0. An alloc alone may fire.

## Timing
- Reset values:
  - head = 0, tail = 0, occupancy = 0.
  - empty = 1, full = 0.
  - alloc_idx = 0, commit_idx = 0.
  - alloc_ready = 1 and commit_ready = 0 (given flush_valid = 0).
- alloc_ready and commit_ready are combinational from the registered full/empty and flush_valid. No other input-to-output combinational path exists.
- alloc_idx and commit_idx are valid in the grant cycle. Pointers update at the next edge, so latency is 1 cycle to the new head/tail/occupancy.
- Flush takes effect at the next edge. Allocation may resume in the following cycle, at index flush_idx.
- Reset mid-operation overrides all requests, including a flush, and returns every register to its reset value in one edge.
- Throughput: one alloc plus one commit per cycle, sustained, including across the ROB_SIZE-1 -> 0 wrap.

## Structure
- Package rob_pkg:
  - ROB_SIZE and ROB_IDX_W constants.
  - rob_idx_t typedef.
  - rob_cnt_t (ROB_IDX_W+1 bits) typedef.
  - Functions rob_inc(idx) and rob_dist(from, to).
- Sub-module rob_idx_counter: wrap-at-ROB_SIZE index register with increment enable and synchronous load (load has priority over increment). Instantiated twice, as head (no load used) and tail (load = flush).
- Occupancy, full/empty and ready logic live in rob_ptr_ctrl.

## Test plan
- Reset then 40 consecutive allocs -> alloc_idx 0..39 in order; occupancy 40, full = 1, alloc_ready = 0. A 41st request is not granted and tail stays 0.
- Occupancy 5 with alloc and commit both valid for 3 cycles -> occupancy stays 5, head and tail each +3. Wrap case: head 38 -> 39 -> 0.
- head = 10, tail = 20, flush_idx = 15 -> next cycle tail = 15, occupancy = 5, head = 10. alloc_ready and commit_ready are 0 in the flush cycle.
- Wrapped flush: head = 35, tail = 10, flush_idx = 3 -> occupancy = 8. A flush with flush_idx = 35 -> occupancy = 0, empty = 1.
- Full ROB with commit only -> head +1, occupancy 39, full = 0 next cycle. alloc_ready = 1 the following cycle at alloc_idx = old head.
- Reset asserted mid-stream together with alloc, commit and flush -> all registers return to reset values next edge. The first post-reset alloc gets index 0.

Source files
------------

// File: rtl/rob_ptr_ctrl_pkg.sv
// Shared ROB sizing, index/count types and ring-index helpers.
package rob_pkg;

  localparam int ROB_SIZE  = 40;
  localparam int ROB_IDX_W = 6;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W:0]   rob_cnt_t;

  // Ring successor: wraps at ROB_SIZE, not at 2^ROB_IDX_W.
  function automatic rob_idx_t rob_inc(input rob_idx_t idx);
    return (idx == rob_idx_t'(ROB_SIZE - 1)) ? '0 : idx + rob_idx_t'(1);
  endfunction

  // Number of entries from 'from' (inclusive) up to 'to' (exclusive) around the ring.
  function automatic rob_cnt_t rob_dist(input rob_idx_t from, input rob_idx_t to);
    logic signed [ROB_IDX_W+1:0] d;
    d = $signed({2'b00, to}) - $signed({2'b00, from});
    if (d < 0) d = d + $signed((ROB_IDX_W+2)'(ROB_SIZE));
    return d[ROB_IDX_W:0];
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl_if.sv
// Dispatch / commit / flush handshake bundle between the pipeline and the ROB pointer controller.
interface rob_ptr_ctrl_if #(
  parameter int ROB_IDX_W = rob_pkg::ROB_IDX_W
);
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [ROB_IDX_W-1:0] alloc_idx;
  logic                 commit_valid;
  logic                 commit_ready;
  logic [ROB_IDX_W-1:0] commit_idx;
  logic                 flush_valid;
  logic [ROB_IDX_W-1:0] flush_idx;

  modport master (
    output alloc_valid, commit_valid, flush_valid, flush_idx,
    input  alloc_ready, alloc_idx, commit_ready, commit_idx
  );

  modport slave (
    input  alloc_valid, commit_valid, flush_valid, flush_idx,
    output alloc_ready, alloc_idx, commit_ready, commit_idx
  );
endinterface

// File: rtl/rob_idx_counter.sv
// Ring index register wrapping at ROB_SIZE; synchronous load wins over increment.
module rob_idx_counter #(
  parameter int ROB_SIZE  = rob_pkg::ROB_SIZE,
  parameter int ROB_IDX_W = rob_pkg::ROB_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 load,
  input  logic [ROB_IDX_W-1:0] load_val,
  output logic [ROB_IDX_W-1:0] idx
);
  import rob_pkg::*;

  localparam logic [ROB_IDX_W-1:0] LAST_IDX = ROB_IDX_W'(ROB_SIZE - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (load) begin
      idx <= load_val;
    end else if (inc) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + ROB_IDX_W'(1);
    end
  end

endmodule

// File: rtl/rob_ptr_ctrl.sv
// ROB head/tail/occupancy controller: one alloc and one commit per cycle, flush rolls tail back.
module rob_ptr_ctrl
  import rob_pkg::*;
#(
  parameter int ROB_SIZE  = rob_pkg::ROB_SIZE,
  parameter int ROB_IDX_W = rob_pkg::ROB_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  rob_ptr_ctrl_if.slave        bus,
  output logic [ROB_IDX_W-1:0] head,
  output logic [ROB_IDX_W-1:0] tail,
  output logic [ROB_IDX_W:0]   occupancy,
  output logic                 full,
  output logic                 empty
);

  localparam logic [ROB_IDX_W:0] SIZE_CNT = (ROB_IDX_W+1)'(ROB_SIZE);
  localparam logic [ROB_IDX_W:0] ONE_CNT  = (ROB_IDX_W+1)'(1);

  // Distance computed one bit wider and signed so the wrap correction is a plain add.
  function automatic logic [ROB_IDX_W:0] ring_dist(input logic [ROB_IDX_W-1:0] from,
                                                    input logic [ROB_IDX_W-1:0] to);
    logic signed [ROB_IDX_W+1:0] d;
    d = $signed({2'b00, to}) - $signed({2'b00, from});
    if (d < 0) d = d + $signed((ROB_IDX_W+2)'(ROB_SIZE));
    return d[ROB_IDX_W:0];
  endfunction

  logic               full_r;
  logic               empty_r;
  logic [ROB_IDX_W:0] occ_r;
  logic [ROB_IDX_W:0] occ_n;
  logic               alloc_fire;
  logic               commit_fire;

  assign bus.alloc_ready  = !full_r  && !bus.flush_valid;
  assign bus.commit_ready = !empty_r && !bus.flush_valid;
  assign alloc_fire       = bus.alloc_valid  && bus.alloc_ready;
  assign commit_fire      = bus.commit_valid && bus.commit_ready;

  assign bus.alloc_idx  = tail;
  assign bus.commit_idx = head;
  assign occupancy      = occ_r;
  assign full           = full_r;
  assign empty          = empty_r;

  rob_idx_counter #(.ROB_SIZE(ROB_SIZE), .ROB_IDX_W(ROB_IDX_W)) u_head (
    .clk      (clk),
    .reset    (reset),
    .inc      (commit_fire),
    .load     (1'b0),
    .load_val ('0),
    .idx      (head)
  );

  rob_idx_counter #(.ROB_SIZE(ROB_SIZE), .ROB_IDX_W(ROB_IDX_W)) u_tail (
    .clk      (clk),
    .reset    (reset),
    .inc      (alloc_fire),
    .load     (bus.flush_valid),
    .load_val (bus.flush_idx),
    .idx      (tail)
  );

  always_comb begin
    occ_n = occ_r;
    if (bus.flush_valid) begin
      occ_n = ring_dist(head, bus.flush_idx);
    end else if (alloc_fire && !commit_fire) begin
      occ_n = occ_r + ONE_CNT;
    end else if (commit_fire && !alloc_fire) begin
      occ_n = occ_r - ONE_CNT;
    end
  end

  // full/empty are registered from next occupancy so the ready paths start at a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      occ_r   <= occ_n;
      full_r  <= (occ_n == SIZE_CNT);
      empty_r <= (occ_n == '0);
    end
  end

endmodule
